// File: rtl/updown_counter_pkg.sv
// updown_counter_pkg: shared encodings for the up/down counter's mode and direction inputs
package updown_counter_pkg;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;
    localparam logic DIR_UP    = 1'b0;
    localparam logic DIR_DOWN  = 1'b1;
endpackage

// File: rtl/updown_prescaler.sv
// updown_prescaler: counts enabled cycles 0..PRESCALE-1 and ticks on the terminal one
module updown_prescaler
    import updown_counter_pkg::*;
#(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int WIDTH = $clog2(PRESCALE) + 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(PRESCALE - 1);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    assign tick = en & (cnt_q == LAST);
    always_comb cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + WIDTH'(1);
    always_ff @(posedge clk) cnt_q <= !n_rst ? '0 : cnt_d;
endmodule

// File: rtl/updown_counter_n.sv
// updown_counter_n: bounded up/down counter with wrap/saturate, load, flags and ovf/unf pulses
// Optional step prescaler enabled by defining UDCNT_PRESCALE_EN.
module updown_counter_n
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter int RST_VAL  = MIN_VAL,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    input  logic             trig,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf
);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_W = WIDTH'(RST_VAL);
    logic [WIDTH-1:0] out_q, out_d;
    logic ovf_q, ovf_d, unf_q, unf_d, step;
`ifdef UDCNT_PRESCALE_EN
    updown_prescaler #(.PRESCALE(PRESCALE)) u_pre (
        .clk  (clk),
        .n_rst(n_rst),
        .en   (en),
        .clr  (load),
        .tick (step)
    );
`else
    // PRESCALE only matters with the prescaler; an invalid value still blocks stepping
    assign step = en & (PRESCALE >= 1);
`endif
    assign at_max = out_q == MAX_W;
    assign at_min = out_q == MIN_W;
    // Bound compares only, so the counter never relies on native 2^WIDTH wrap
    always_comb begin
        out_d = out_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (load)
            out_d = load_val < MIN_W ? MIN_W : load_val > MAX_W ? MAX_W : load_val;
        else if (step && trig == DIR_UP) begin
            ovf_d = at_max;
            out_d = !at_max ? out_q + WIDTH'(1) : mode == MODE_WRAP ? MIN_W : out_q;
        end else if (step && trig == DIR_DOWN) begin
            unf_d = at_min;
            out_d = !at_min ? out_q - WIDTH'(1) : mode == MODE_SAT ? out_q : MAX_W;
        end
    end
    always_ff @(posedge clk) begin
        out_q <= !n_rst ? RST_W : out_d;
        ovf_q <= n_rst & ovf_d;
        unf_q <= n_rst & unf_d;
    end
    assign out = out_q;
    assign ovf = ovf_q;
    assign unf = unf_q;
endmodule
